// File: rtl/vector_scale_pkg.sv
// Shared definitions for the vector arithmetic stages.
// Provides the state encodings and a ceiling-log2 helper.
package vector_scale_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_RUN   = ST_RUN_ENC,
    S_DRAIN = ST_DRAIN_ENC
  } state_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int log2(input int value);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= value) return r;
    end
    return 31;
  endfunction

endpackage

// File: rtl/vector_scale_fixed_saturate.sv
// Combinational arithmetic right shift followed by signed saturation.
// Reusable by any fixed-point stage that narrows a wide product or sum.
module fixed_saturate #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 4
) (
  input  logic signed [IN_WIDTH-1:0]  i_value,
  output logic signed [OUT_WIDTH-1:0] o_value,
  output logic                        o_overflow
);

  localparam logic signed [IN_WIDTH-1:0] MAX_VAL =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] MIN_VAL =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [IN_WIDTH-1:0] w_shifted;

  always_comb begin
    w_shifted  = i_value >>> SHIFT;
    o_value    = w_shifted[OUT_WIDTH-1:0];
    o_overflow = 1'b0;
    if (w_shifted > MAX_VAL) begin
      o_value    = MAX_VAL[OUT_WIDTH-1:0];
      o_overflow = 1'b1;
    end else if (w_shifted < MIN_VAL) begin
      o_value    = MIN_VAL[OUT_WIDTH-1:0];
      o_overflow = 1'b1;
    end
  end

endmodule

// File: rtl/vector_scale.sv
// Serial fixed-point vector-by-scalar multiplier with a two-stage
// multiply/saturate pipeline processing TILING elements per cycle.
module vector_scale
  import vector_scale_pkg::*;
#(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int SCALAR_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION          = 4,
  parameter int TILING            = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]        a,
  input  logic [SCALAR_WIDTH-1:0]                   scalar,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0]   result,
  output logic                                      valid,
  output logic                                      busy,
  output logic                                      error
);

  localparam int PW     = A_CELL_WIDTH + SCALAR_WIDTH;
  localparam int GROUPS = (VECTOR_LEN + TILING - 1) / TILING;
  localparam int CNT_W  = log2(VECTOR_LEN + TILING) + 1;
  localparam logic [CNT_W-1:0] LAST_BASE = CNT_W'((GROUPS - 1) * TILING);

  state_t r_state;
  state_t w_nextState;

  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      r_a;
  logic signed [SCALAR_WIDTH-1:0]          r_scalar;
  logic [CNT_W-1:0]                        r_counter;
  logic [CNT_W-1:0]                        r_base;
  logic                                    r_pipeValid;
  logic [TILING-1:0]                       r_laneValid;
  logic signed [PW-1:0]                    r_prod [TILING];
  logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] r_result;
  logic                                    r_valid;
  logic                                    r_error;

  logic                                    w_lastGroup;
  logic signed [A_CELL_WIDTH-1:0]          w_laneA [TILING];
  logic signed [PW-1:0]                    w_prod [TILING];
  logic signed [RESULT_CELL_WIDTH-1:0]     w_satValue [TILING];
  logic [TILING-1:0]                       w_satFlag;

  assign w_lastGroup = (r_counter == LAST_BASE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_RUN;
      S_RUN:   if (w_lastGroup) w_nextState = S_DRAIN;
      S_DRAIN: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Lane selection compares against every element so no index leaves range.
  always_comb begin
    for (int k = 0; k < TILING; k++) begin
      w_laneA[k] = '0;
      for (int i = 0; i < VECTOR_LEN; i++) begin
        if (int'(r_counter) + k == i) w_laneA[k] = r_a[i*A_CELL_WIDTH +: A_CELL_WIDTH];
      end
      w_prod[k] = PW'(w_laneA[k]) * PW'(r_scalar);
    end
  end

  for (genvar k = 0; k < TILING; k++) begin : g_lane
    fixed_saturate #(
      .IN_WIDTH (PW),
      .OUT_WIDTH(RESULT_CELL_WIDTH),
      .SHIFT    (FRACTION)
    ) u_sat (
      .i_value   (r_prod[k]),
      .o_value   (w_satValue[k]),
      .o_overflow(w_satFlag[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a         <= '0;
      r_scalar    <= '0;
      r_counter   <= '0;
      r_base      <= '0;
      r_pipeValid <= 1'b0;
      r_laneValid <= '0;
      r_result    <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      for (int k = 0; k < TILING; k++) r_prod[k] <= '0;
    end else begin
      r_pipeValid <= (r_state == S_RUN);

      if (r_state == S_IDLE && start) begin
        r_a       <= a;
        r_scalar  <= scalar;
        r_valid   <= 1'b0;
        r_error   <= 1'b0;
        r_counter <= '0;
      end

      if (r_state == S_RUN) begin
        for (int k = 0; k < TILING; k++) begin
          r_prod[k]      <= w_prod[k];
          r_laneValid[k] <= (int'(r_counter) + k < VECTOR_LEN);
        end
        r_base <= r_counter;
        if (!w_lastGroup) r_counter <= r_counter + CNT_W'(TILING);
      end

      if (r_pipeValid) begin
        for (int i = 0; i < VECTOR_LEN; i++) begin
          for (int k = 0; k < TILING; k++) begin
            if (r_laneValid[k] && (int'(r_base) + k == i))
              r_result[i*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] <= w_satValue[k];
          end
        end
        if (|(w_satFlag & r_laneValid)) r_error <= 1'b1;
      end

      if (r_state == S_DRAIN) r_valid <= 1'b1;
    end
  end

  assign result = r_result;
  assign valid  = r_valid;
  assign error  = r_error;
  assign busy   = (r_state != S_IDLE);

endmodule
